// File: rtl/dnn_accel_debug_pkg.sv
// dnn_accel_debug_pkg: shared state encoding and jdo field positions for the debug monitor master.
package dnn_accel_debug_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;
  localparam int JDO_RD_LAUNCH = 35;
  localparam int JDO_AUTOINC   = 34;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_ADDR_LSB  = 2;
endpackage

// File: rtl/dnn_accel_debug_mon_timeout.sv
// dnn_accel_debug_mon_timeout: loadable down-counter that flags expiry on reaching zero.
module dnn_accel_debug_mon_timeout #(
  parameter int COUNT = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);
  localparam int W = $clog2(COUNT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = load_i ? W'(COUNT - 1) : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  assign expired_o = cnt_q == '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= W'(COUNT - 1);
    else cnt_q <= cnt_d;
endmodule

// File: rtl/system.sv
// system: debug monitor master turning OCI memory commands into single-word Avalon-MM transfers.
// Optional waitrequest timeout is enabled by defining DNN_ACCEL_DEBUG_MON_TIMEOUT_EN.
module system
  import dnn_accel_debug_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W+1:0] aaddr_q, aaddr_d;
  logic [31:0]       wdata_q, wdata_d, mon_q, mon_d;
  logic              autoinc_q, autoinc_d, rd_q, rd_d, wr_q, wr_d;
  logic              ready_q, ready_d, err_q, err_d;
  logic              busy, done, timeout, launch, rd_cmd, wr_cmd;
  logic              unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};
  assign busy   = state_q != IDLE;
  assign done   = busy && !avm_waitrequest;
  assign launch = take_action_ocimem_a && jdo[JDO_RD_LAUNCH];
  assign wr_cmd = !take_action_ocimem_a && take_action_ocimem_b;
  assign rd_cmd = launch || (!take_action_ocimem_a && !take_action_ocimem_b && take_no_action_ocimem_a);
`ifdef DNN_ACCEL_DEBUG_MON_TIMEOUT_EN
  logic expired;
  dnn_accel_debug_mon_timeout #(.COUNT(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (!busy),
    .dec_i    (busy && avm_waitrequest),
    .expired_o(expired)
  );
  assign timeout = busy && avm_waitrequest && expired;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    aaddr_d   = aaddr_q;
    wdata_d   = wdata_q;
    mon_d     = mon_q;
    autoinc_d = autoinc_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    ready_d   = ready_q;
    err_d     = err_q;
    if (done) begin
      state_d = IDLE;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      ready_d = 1'b1;
      mon_d   = state_q == READ ? avm_readdata : mon_q;
      addr_d  = autoinc_q ? addr_q + 1'b1 : addr_q;
    end else if (timeout) begin
      state_d = IDLE;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      ready_d = 1'b1;
    end else if (!busy && (rd_cmd || wr_cmd)) begin
      state_d = rd_cmd ? READ : WRITE;
      rd_d    = rd_cmd;
      wr_d    = wr_cmd;
      ready_d = 1'b0;
      aaddr_d = {(launch ? jdo[JDO_ADDR_LSB +: ADDR_W] : addr_q), 2'b00};
      wdata_d = wr_cmd ? jdo[JDO_WDATA_LSB +: 32] : wdata_q;
      mon_d   = wr_cmd ? jdo[JDO_WDATA_LSB +: 32] : mon_q;
    end
    // An explicit address load wins over the autoincrement of a completing transfer
    if (take_action_ocimem_a) begin
      addr_d    = jdo[JDO_ADDR_LSB +: ADDR_W];
      autoinc_d = jdo[JDO_AUTOINC];
      err_d     = 1'b0;
    end
    if (timeout || (busy && (rd_cmd || wr_cmd))) err_d = 1'b1;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      aaddr_q   <= '0;
      wdata_q   <= '0;
      mon_q     <= '0;
      autoinc_q <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      aaddr_q   <= aaddr_d;
      wdata_q   <= wdata_d;
      mon_q     <= mon_d;
      autoinc_q <= autoinc_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  assign avm_address    = aaddr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'hF;
  assign MonDReg        = mon_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = err_q;
endmodule

// File: tb/tb_system.sv
// tb_system: scoreboard bench for the debug monitor master; the timeout scenario runs when DNN_ACCEL_DEBUG_MON_TIMEOUT_EN is defined.
module tb_system;
  localparam int AW = 16;
  typedef struct packed {
    logic          w;
    logic [AW+1:0] addr;
    logic [31:0]   data;
  } xfer_t;
  logic          clk = 1'b0, reset_n = 1'b0;
  logic [37:0]   jdo = '0;
  logic          ta = 1'b0, tn = 1'b0, tbw = 1'b0;
  logic [AW+1:0] avm_address;
  logic          avm_read, avm_write;
  logic [31:0]   avm_writedata;
  logic [3:0]    avm_byteenable;
  logic [31:0]   avm_readdata = '0;
  logic          avm_waitrequest = 1'b0;
  logic [31:0]   MonDReg;
  logic          monitor_ready, monitor_error;
  xfer_t         exp_q[$];
  int            pass_cnt = 0, total_cnt = 0;
  int            stall_cfg = 0, scnt = 0;

  system #(.ADDR_W(AW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(ta), .take_no_action_ocimem_a(tn), .take_action_ocimem_b(tbw),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  // Slave: stalls each request for stall_cfg cycles, decided at the falling edge
  always @(negedge clk)
    if (avm_read || avm_write) begin
      avm_waitrequest = scnt < stall_cfg;
      scnt = scnt + 1;
    end else begin
      avm_waitrequest = 1'b0;
      scnt = 0;
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic strobe(input logic a, input logic n, input logic b, input logic [37:0] d);
    ta = a; tn = n; tbw = b; jdo = d;
    @(posedge clk); #1;
    ta = 1'b0; tn = 1'b0; tbw = 1'b0;
  endtask

  task automatic drain(output int n, output int cyc);
    xfer_t e;
    n = 0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if ((avm_read || avm_write) && !avm_waitrequest) begin
        n++;
        total_cnt++;
        if (exp_q.size() == 0)
          $display("FAIL sb_extra: got w=%0b addr=%h, expected no transfer", avm_write, avm_address);
        else begin
          e = exp_q.pop_front();
          if (avm_write !== e.w || avm_address !== e.addr || (e.w && avm_writedata !== e.data))
            $display("FAIL sb_xfer: got w=%0b addr=%h data=%h, expected w=%0b addr=%h data=%h",
                     avm_write, avm_address, avm_writedata, e.w, e.addr, e.data);
          else pass_cnt++;
        end
      end
      @(posedge clk); #1;
      if (monitor_ready) begin
        cyc = i + 1;
        return;
      end
    end
    total_cnt++;
    $display("FAIL drain_timeout: monitor_ready=0 after 40 cycles, expected 1");
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({avm_read, avm_write, monitor_ready, monitor_error} !== 4'b0010)
      $display("FAIL reset_flags: got rd/wr/rdy/err=%b, expected 0010", {avm_read, avm_write, monitor_ready, monitor_error});
    else pass_cnt++;
    total_cnt++;
    if (avm_address !== '0 || avm_writedata !== '0 || MonDReg !== '0)
      $display("FAIL reset_data: got addr=%h wdata=%h mon=%h, expected all 0", avm_address, avm_writedata, MonDReg);
    else pass_cnt++;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_read();
    int n, cyc;
    stall_cfg = 0;
    avm_readdata = 32'hDEADBEEF;
    exp_q.push_back(xfer_t'{1'b0, 18'h00040, 32'h0});
    strobe(1'b1, 1'b0, 1'b0, (38'd1 << 35) | (38'h10 << 2));
    total_cnt++;
    if (avm_read !== 1'b1 || avm_address !== 18'h00040 || monitor_ready !== 1'b0 || avm_byteenable !== 4'hF)
      $display("FAIL load_read_issue: got rd=%b addr=%h rdy=%b be=%h, expected 1 00040 0 f",
               avm_read, avm_address, monitor_ready, avm_byteenable);
    else pass_cnt++;
    drain(n, cyc);
    total_cnt++;
    if (cyc !== 1 || MonDReg !== 32'hDEADBEEF || avm_read !== 1'b0)
      $display("FAIL load_read_done: got cyc=%0d mon=%h rd=%b, expected 1 deadbeef 0", cyc, MonDReg, avm_read);
    else pass_cnt++;
  endtask

  task automatic test_autoinc_burst();
    int n, cyc;
    strobe(1'b1, 1'b0, 1'b0, (38'd1 << 34) | (38'hFFFF << 2));
    total_cnt++;
    if (avm_read !== 1'b0 || avm_write !== 1'b0 || monitor_ready !== 1'b1)
      $display("FAIL load_only: got rd=%b wr=%b rdy=%b, expected 0 0 1", avm_read, avm_write, monitor_ready);
    else pass_cnt++;
    exp_q.push_back(xfer_t'{1'b1, 18'h3FFFC, 32'h11});
    strobe(1'b0, 1'b0, 1'b1, 38'h11 << 3);
    total_cnt++;
    if (avm_write !== 1'b1 || MonDReg !== 32'h11)
      $display("FAIL burst_w1_issue: got wr=%b mon=%h, expected 1 00000011", avm_write, MonDReg);
    else pass_cnt++;
    drain(n, cyc);
    exp_q.push_back(xfer_t'{1'b1, 18'h00000, 32'h22});
    strobe(1'b0, 1'b0, 1'b1, 38'h22 << 3);
    drain(n, cyc);
    total_cnt++;
    if (MonDReg !== 32'h22 || exp_q.size() != 0)
      $display("FAIL burst_done: got mon=%h pending=%0d, expected 00000022 0", MonDReg, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int n, cyc;
    logic quiet;
    stall_cfg = 5;
    avm_readdata = 32'hCAFE0001;
    exp_q.push_back(xfer_t'{1'b0, 18'h00004, 32'h0});
    strobe(1'b0, 1'b1, 1'b0, '0);
    total_cnt++;
    if (avm_read !== 1'b1 || monitor_error !== 1'b0)
      $display("FAIL overrun_issue: got rd=%b err=%b, expected 1 0", avm_read, monitor_error);
    else pass_cnt++;
    strobe(1'b0, 1'b1, 1'b0, '0);
    total_cnt++;
    if (monitor_error !== 1'b1 || avm_read !== 1'b1 || avm_address !== 18'h00004)
      $display("FAIL overrun_flag: got err=%b rd=%b addr=%h, expected 1 1 00004", monitor_error, avm_read, avm_address);
    else pass_cnt++;
    drain(n, cyc);
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (avm_read || avm_write) quiet = 1'b0;
    end
    total_cnt++;
    if (n !== 1 || quiet !== 1'b1 || MonDReg !== 32'hCAFE0001 || monitor_error !== 1'b1)
      $display("FAIL overrun_single: got n=%0d quiet=%b mon=%h err=%b, expected 1 1 cafe0001 1", n, quiet, MonDReg, monitor_error);
    else pass_cnt++;
    stall_cfg = 0;
    strobe(1'b1, 1'b0, 1'b0, 38'h30 << 2);
    total_cnt++;
    if (monitor_error !== 1'b0)
      $display("FAIL overrun_clear: got err=%b, expected 0", monitor_error);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int n, cyc;
    logic quiet;
    strobe(1'b1, 1'b0, 1'b1, 38'h55 << 2);
    quiet = !(avm_read || avm_write);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (avm_read || avm_write) quiet = 1'b0;
    end
    total_cnt++;
    if (quiet !== 1'b1 || monitor_ready !== 1'b1 || monitor_error !== 1'b0)
      $display("FAIL simul_quiet: got quiet=%b rdy=%b err=%b, expected 1 1 0", quiet, monitor_ready, monitor_error);
    else pass_cnt++;
    avm_readdata = 32'h12345678;
    exp_q.push_back(xfer_t'{1'b0, 18'h00154, 32'h0});
    strobe(1'b0, 1'b1, 1'b0, '0);
    drain(n, cyc);
    total_cnt++;
    if (n !== 1 || MonDReg !== 32'h12345678)
      $display("FAIL simul_addr: got n=%0d mon=%h, expected 1 12345678", n, MonDReg);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n, cyc;
    avm_readdata = 32'h0000000A;
    exp_q.push_back(xfer_t'{1'b0, 18'h00014, 32'h0});
    strobe(1'b1, 1'b0, 1'b0, (38'd1 << 35) | (38'd1 << 34) | (38'h5 << 2));
    drain(n, cyc);
    avm_readdata = 32'h0000000B;
    exp_q.push_back(xfer_t'{1'b0, 18'h00018, 32'h0});
    strobe(1'b0, 1'b1, 1'b0, '0);
    total_cnt++;
    if (avm_read !== 1'b1 || monitor_error !== 1'b0)
      $display("FAIL b2b_accept: got rd=%b err=%b, expected 1 0", avm_read, monitor_error);
    else pass_cnt++;
    drain(n, cyc);
    total_cnt++;
    if (MonDReg !== 32'h0000000B || exp_q.size() != 0)
      $display("FAIL b2b_done: got mon=%h pending=%0d, expected 0000000b 0", MonDReg, exp_q.size());
    else pass_cnt++;
  endtask

`ifdef DNN_ACCEL_DEBUG_MON_TIMEOUT_EN
  task automatic test_timeout();
    int cnt;
    logic [31:0] mon_before;
    stall_cfg = 1000;
    mon_before = MonDReg;
    strobe(1'b0, 1'b1, 1'b0, '0);
    cnt = 0;
    while (avm_read && cnt < 50) begin
      cnt++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (cnt !== 8 || monitor_error !== 1'b1 || monitor_ready !== 1'b1 || MonDReg !== mon_before)
      $display("FAIL timeout: got cycles=%0d err=%b rdy=%b mon=%h, expected 8 1 1 %h",
               cnt, monitor_error, monitor_ready, MonDReg, mon_before);
    else pass_cnt++;
    stall_cfg = 0;
  endtask
`endif

  task automatic test_reset_mid_write();
    stall_cfg = 1000;
    strobe(1'b0, 1'b0, 1'b1, 38'hABCD << 3);
    @(posedge clk); #1;
    total_cnt++;
    if (avm_write !== 1'b1 || avm_writedata !== 32'h0000ABCD)
      $display("FAIL rst_stall: got wr=%b wdata=%h, expected 1 0000abcd", avm_write, avm_writedata);
    else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({avm_read, avm_write, monitor_ready, monitor_error} !== 4'b0010 ||
        avm_address !== '0 || avm_writedata !== '0 || MonDReg !== '0)
      $display("FAIL rst_async: got rd/wr/rdy/err=%b addr=%h wdata=%h mon=%h, expected 0010 0 0 0",
               {avm_read, avm_write, monitor_ready, monitor_error}, avm_address, avm_writedata, MonDReg);
    else pass_cnt++;
    stall_cfg = 0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (avm_write !== 1'b0 || monitor_ready !== 1'b1)
      $display("FAIL rst_recover: got wr=%b rdy=%b, expected 0 1", avm_write, monitor_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_autoinc_burst();
    test_overrun();
    test_simultaneous();
    test_back_to_back();
`ifdef DNN_ACCEL_DEBUG_MON_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
